// File: rtl/muldiv_unit_if.sv
// ============================================================================
// Module  : muldiv_unit_if
// Brief   : Request/response channel bundle for muldiv_unit, with flush/busy.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface muldiv_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             flush;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [XLEN-1:0]  req_op1;
  logic [XLEN-1:0]  req_op2;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic [XLEN-1:0]  resp_result;
  logic [TAG_W-1:0] resp_tag;
  logic             busy;

  modport master (
    output flush, req_valid, req_op, req_op1, req_op2, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_tag, busy
  );

  modport slave (
    input  flush, req_valid, req_op, req_op1, req_op2, req_tag, resp_ready,
    output req_ready, resp_valid, resp_result, resp_tag, busy
  );
endinterface

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module  : muldiv_unit
// Brief   : Multi-cycle RV32M/RV64M multiply/divide unit with tagged response.
//           Optional macro MULDIV_FAST_MUL_EN: single-cycle combinational multiply.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);

  localparam int              CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] C_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [2:0]         r_op;
  logic               r_neg;
  logic [XLEN-1:0]    r_opnd;
  logic [2*XLEN-1:0]  r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_resp_valid;
  logic [XLEN-1:0]    r_result;
  logic [TAG_W-1:0]   r_tag;
  logic               r_busy;

  logic [2:0]         w_op;
  logic               w_s1, w_s2, w_n1, w_n2;
  logic [XLEN-1:0]    w_mag1, w_mag2;
  logic               w_ready, w_accept, w_div0, w_ovf;
  logic [XLEN:0]      w_mul_sum, w_rem_sh, w_diff;
  logic [2*XLEN-1:0]  w_acc_nxt, w_prod;
  logic [XLEN-1:0]    w_dv, w_dv_s, w_final;

  // Signedness per funct3: MUL/MULH signed x signed, MULHSU signed x unsigned.
  assign w_op   = bus.req_op;
  assign w_s1   = w_op[2] ? !w_op[0] : (w_op != 3'd3);
  assign w_s2   = w_op[2] ? !w_op[0] : !w_op[1];
  assign w_n1   = w_s1 & bus.req_op1[XLEN-1];
  assign w_n2   = w_s2 & bus.req_op2[XLEN-1];
  assign w_mag1 = w_n1 ? ('0 - bus.req_op1) : bus.req_op1;
  assign w_mag2 = w_n2 ? ('0 - bus.req_op2) : bus.req_op2;

  assign w_ready  = (r_state == S_IDLE) && !bus.flush && !rst;
  assign w_accept = bus.req_valid && w_ready;
  assign w_div0   = w_op[2] && (bus.req_op2 == '0);
  assign w_ovf    = w_op[2] && !w_op[0] && (bus.req_op1 == C_MIN) && (bus.req_op2 == '1);

  // r_acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_rem_sh  = r_acc[2*XLEN-1:XLEN-1];
  assign w_diff    = w_rem_sh - {1'b0, r_opnd};
  assign w_acc_nxt = r_op[2]
                   ? (w_diff[XLEN] ? {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                   : {w_diff[XLEN-1:0],   r_acc[XLEN-2:0], 1'b1})
                   : {w_mul_sum, r_acc[XLEN-1:1]};

  assign w_prod  = r_neg ? ('0 - w_acc_nxt) : w_acc_nxt;
  assign w_dv    = r_op[1] ? w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[XLEN-1:0];
  assign w_dv_s  = r_neg ? ('0 - w_dv) : w_dv;
  assign w_final = r_op[2] ? w_dv_s
                 : ((r_op[1:0] == 2'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);

`ifdef MULDIV_FAST_MUL_EN
  // Sign-extending to 2*XLEN makes the truncated unsigned product the signed one.
  logic [2*XLEN-1:0] w_fa, w_fb, w_fp;
  logic [XLEN-1:0]   w_fast_res;
  assign w_fa       = {{XLEN{w_n1}}, bus.req_op1};
  assign w_fb       = {{XLEN{w_n2}}, bus.req_op2};
  assign w_fp       = w_fa * w_fb;
  assign w_fast_res = (w_op[1:0] == 2'd0) ? w_fp[XLEN-1:0] : w_fp[2*XLEN-1:XLEN];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_op         <= '0;
      r_neg        <= 1'b0;
      r_opnd       <= '0;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_resp_valid <= 1'b0;
      r_result     <= '0;
      r_tag        <= '0;
      r_busy       <= 1'b0;
    end else if (bus.flush) begin
      r_state      <= S_IDLE;
      r_resp_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op   <= w_op;
            r_tag  <= bus.req_tag;
            r_busy <= 1'b1;
            if (w_div0) begin
              r_result     <= w_op[1] ? bus.req_op1 : '1;
              r_resp_valid <= 1'b1;
              r_state      <= S_DONE;
            end else if (w_ovf) begin
              r_result     <= w_op[1] ? '0 : bus.req_op1;
              r_resp_valid <= 1'b1;
              r_state      <= S_DONE;
`ifdef MULDIV_FAST_MUL_EN
            end else if (!w_op[2]) begin
              r_result     <= w_fast_res;
              r_resp_valid <= 1'b1;
              r_state      <= S_DONE;
`endif
            end else begin
              r_cnt   <= CNT_W'(XLEN);
              r_state <= S_CALC;
              if (w_op[2]) begin
                r_opnd <= w_mag2;
                r_acc  <= {{XLEN{1'b0}}, w_mag1};
                r_neg  <= w_op[1] ? w_n1 : (w_n1 ^ w_n2);
              end else begin
                r_opnd <= w_mag1;
                r_acc  <= {{XLEN{1'b0}}, w_mag2};
                r_neg  <= w_n1 ^ w_n2;
              end
            end
          end
        end
        S_CALC: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_result     <= w_final;
            r_resp_valid <= 1'b1;
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready   = w_ready;
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_result = r_result;
  assign bus.resp_tag    = r_tag;
  assign bus.busy        = r_busy;

endmodule

`default_nettype wire
